// File: rtl/elevator_plant.sv
// Elevator car, shaft and door plant model.
// Consumes the controller's engine/door commands and produces the floor and
// door sensors. Illegal plant usage is latched in sticky fault flags.
module elevator_plant #(
    parameter int FLOORS        = 8,
    parameter int TRAVEL_CYCLES = 1000,
    parameter int DOOR_CYCLES   = 500,
    parameter int RESET_FLOOR   = 0,
    parameter int RESET_STEP    = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                engine,
    input  logic [1:0]                door,
    output logic                      sensor_up,
    output logic                      sensor_down,
    output logic [1:0]                sensor_door,
    output logic [$clog2(FLOORS)-1:0] car_floor,
    output logic                      at_floor,
    output logic [2:0]                fault
);

    localparam int FW = $clog2(FLOORS);
    localparam int SW = $clog2(TRAVEL_CYCLES);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    localparam logic [FW-1:0] FLOOR_TOP  = FW'(FLOORS - 1);
    localparam logic [FW-1:0] FLOOR_INIT = FW'(RESET_FLOOR);
    localparam logic [SW-1:0] STEP_MAX   = SW'(TRAVEL_CYCLES - 1);
    localparam logic [SW-1:0] STEP_INIT  = SW'(RESET_STEP);
    localparam logic [SW-1:0] STEP_ONE   = SW'(1);
    localparam logic [DW-1:0] DPOS_OPEN  = DW'(DOOR_CYCLES);
    localparam logic [DW-1:0] DPOS_ONE   = DW'(1);
    localparam logic [FW-1:0] FLOOR_ONE  = FW'(1);

    logic [FW-1:0] floor_q, floor_d;
    logic [SW-1:0] step_q, step_d;
    logic [DW-1:0] dpos_q, dpos_d;
    logic          up_d, down_d;
    logic [2:0]    fault_q, fault_d;
    logic          up_q, down_q;

    // Next-state: the door rule is evaluated first against the current engine
    // command, then the engine rule against the current door position.
    always_comb begin
        floor_d = floor_q;
        step_d  = step_q;
        dpos_d  = dpos_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        fault_d = fault_q;

        case (door)
            2'b01: begin
                if (step_q != '0 || engine != 2'b00)
                    fault_d[1] = 1'b1;
                else if (dpos_q != DPOS_OPEN)
                    dpos_d = dpos_q + DPOS_ONE;
            end
            2'b10: begin
                if (step_q != '0 || engine != 2'b00)
                    fault_d[1] = 1'b1;
                else if (dpos_q != '0)
                    dpos_d = dpos_q - DPOS_ONE;
            end
            2'b11:   fault_d[2] = 1'b1;
            default: ;
        endcase

        case (engine)
            2'b01: begin
                if (dpos_q != '0) begin
                    fault_d[0] = 1'b1;
                end else if (floor_q == FLOOR_TOP && step_q == '0) begin
                    fault_d[2] = 1'b1;
                end else if (step_q == STEP_MAX) begin
                    step_d  = '0;
                    floor_d = floor_q + FLOOR_ONE;
                    up_d    = 1'b1;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            2'b10: begin
                if (dpos_q != '0) begin
                    fault_d[0] = 1'b1;
                end else if (floor_q == '0 && step_q == '0) begin
                    fault_d[2] = 1'b1;
                end else if (step_q == '0) begin
                    // Leaving a level downward: the car now sits just above the floor below.
                    floor_d = floor_q - FLOOR_ONE;
                    step_d  = STEP_MAX;
                end else if (step_q == STEP_ONE) begin
                    step_d = '0;
                    down_d = 1'b1;
                end else begin
                    step_d = step_q - STEP_ONE;
                end
            end
            2'b11:   fault_d[2] = 1'b1;
            default: ;
        endcase
    end

    // Plant state register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            floor_q <= FLOOR_INIT;
            step_q  <= STEP_INIT;
            dpos_q  <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            fault_q <= 3'b000;
        end else begin
            floor_q <= floor_d;
            step_q  <= step_d;
            dpos_q  <= dpos_d;
            up_q    <= up_d;
            down_q  <= down_d;
            fault_q <= fault_d;
        end
    end

    // Door sensor decode: closed and fully open are exclusive end stops.
    always_comb begin
        sensor_door = 2'b00;
        if (dpos_q == '0)
            sensor_door = 2'b10;
        else if (dpos_q == DPOS_OPEN)
            sensor_door = 2'b01;
    end

    assign sensor_up   = up_q;
    assign sensor_down = down_q;
    assign car_floor   = floor_q;
    assign at_floor    = (step_q == '0);
    assign fault       = fault_q;

endmodule

// File: tb/tb_elevator_plant.sv
// Directed bench for elevator_plant: a vector table for the main travel and
// door sequences, plus hand-written sequences for interlocks, limits and reset.
module tb_elevator_plant;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] engine;
    logic [1:0] door;

    logic       up0, dn0, at0;
    logic [1:0] sd0;
    logic [2:0] fl0, ft0;
    logic       up7, dn7, at7;
    logic [1:0] sd7;
    logic [2:0] fl7, ft7;
    logic       up4, dn4, at4;
    logic [1:0] sd4;
    logic [2:0] fl4, ft4;

    int checks = 0;
    int errors = 0;

    // Nominal plant: reset at floor 0, level.
    elevator_plant #(.FLOORS(8), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4),
                     .RESET_FLOOR(0), .RESET_STEP(0)) dut0 (
        .clock(clock), .reset(reset), .engine(engine), .door(door),
        .sensor_up(up0), .sensor_down(dn0), .sensor_door(sd0),
        .car_floor(fl0), .at_floor(at0), .fault(ft0));

    // Plant reset at the top floor.
    elevator_plant #(.FLOORS(8), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4),
                     .RESET_FLOOR(7), .RESET_STEP(0)) dut7 (
        .clock(clock), .reset(reset), .engine(engine), .door(door),
        .sensor_up(up7), .sensor_down(dn7), .sensor_door(sd7),
        .car_floor(fl7), .at_floor(at7), .fault(ft7));

    // Plant reset halfway between floors 0 and 1.
    elevator_plant #(.FLOORS(8), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4),
                     .RESET_FLOOR(0), .RESET_STEP(4)) dut4 (
        .clock(clock), .reset(reset), .engine(engine), .door(door),
        .sensor_up(up4), .sensor_down(dn4), .sensor_door(sd4),
        .car_floor(fl4), .at_floor(at4), .fault(ft4));

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  engine;
        logic [1:0]  door;
        logic [10:0] expect_out;
    } vec_t;

    vec_t vecs[$];

    // Output bundle: {sensor_up, sensor_down, sensor_door, car_floor, at_floor, fault}
    function automatic logic [10:0] mk(input bit up, input bit dn, input logic [1:0] sd,
                                       input int fl, input bit at, input logic [2:0] ft);
        return {up, dn, sd, 3'(fl), at, ft};
    endfunction

    function automatic void add(input logic [1:0] e, input logic [1:0] d, input logic [10:0] x);
        vec_t v;
        v.engine     = e;
        v.door       = d;
        v.expect_out = x;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {up,dn,sd,floor,at,fault}=%b want %b", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [1:0] e, input logic [1:0] d);
        engine = e;
        door   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        engine = 2'b00;
        door   = 2'b00;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Travel up two floors, stop, go down one, then a full door stroke each way.
        add(2'b00, 2'b00, mk(0, 0, 2'b10, 0, 1, 3'b000));
        add(2'b00, 2'b00, mk(0, 0, 2'b10, 0, 1, 3'b000));
        for (int i = 1; i <= 16; i++)
            add(2'b01, 2'b00, mk(i % 8 == 0, 0, 2'b10, i / 8, i % 8 == 0, 3'b000));
        add(2'b00, 2'b00, mk(0, 0, 2'b10, 2, 1, 3'b000));
        for (int j = 1; j <= 8; j++)
            add(2'b10, 2'b00, mk(0, j == 8, 2'b10, 1, j == 8, 3'b000));
        for (int k = 1; k <= 4; k++)
            add(2'b00, 2'b01, mk(0, 0, (k == 4) ? 2'b01 : 2'b00, 1, 1, 3'b000));
        add(2'b00, 2'b01, mk(0, 0, 2'b01, 1, 1, 3'b000));
        for (int k = 1; k <= 4; k++)
            add(2'b00, 2'b10, mk(0, 0, (k == 4) ? 2'b10 : 2'b00, 1, 1, 3'b000));
        add(2'b00, 2'b10, mk(0, 0, 2'b10, 1, 1, 3'b000));

        reset  = 1'b1;
        engine = 2'b00;
        door   = 2'b00;
        do_reset();
        check("reset_dut0", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 1, 3'b000));
        check("reset_dut7", {up7, dn7, sd7, fl7, at7, ft7}, mk(0, 0, 2'b10, 7, 1, 3'b000));
        check("reset_dut4", {up4, dn4, sd4, fl4, at4, ft4}, mk(0, 0, 2'b10, 0, 0, 3'b000));

        foreach (vecs[n]) begin
            cycle(vecs[n].engine, vecs[n].door);
            check($sformatf("vec[%0d]", n), {up0, dn0, sd0, fl0, at0, ft0}, vecs[n].expect_out);
        end

        // Door half open, then engine up: car stays put, fault[0].
        do_reset();
        cycle(2'b00, 2'b01);
        cycle(2'b00, 2'b01);
        cycle(2'b01, 2'b00);
        check("engine_door_open", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b00, 0, 1, 3'b001));
        cycle(2'b00, 2'b00);
        check("fault0_sticky", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b00, 0, 1, 3'b001));

        // Off-floor door command: door holds closed, fault[1].
        do_reset();
        cycle(2'b01, 2'b00);
        cycle(2'b01, 2'b00);
        cycle(2'b01, 2'b00);
        cycle(2'b00, 2'b01);
        check("door_off_floor", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 0, 3'b010));

        // Door command concurrent with engine at a level: fault[1] only.
        do_reset();
        cycle(2'b01, 2'b01);
        check("door_with_engine", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 0, 3'b010));

        // Down at floor 0.
        do_reset();
        cycle(2'b10, 2'b00);
        check("bottom_limit", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 1, 3'b100));

        // Up at the top floor.
        do_reset();
        cycle(2'b01, 2'b00);
        check("top_limit", {up7, dn7, sd7, fl7, at7, ft7}, mk(0, 0, 2'b10, 7, 1, 3'b100));

        // Illegal engine and door codes.
        do_reset();
        cycle(2'b11, 2'b00);
        check("engine_illegal", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 1, 3'b100));
        do_reset();
        cycle(2'b00, 2'b11);
        check("door_illegal", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 1, 3'b100));

        // Half-floor reset, moving down reaches floor 0 after 4 cycles.
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            cycle(2'b10, 2'b00);
            check($sformatf("half_down[%0d]", c), {up4, dn4, sd4, fl4, at4, ft4},
                  mk(0, 0, 2'b10, 0, 0, 3'b000));
        end
        cycle(2'b10, 2'b00);
        check("half_down_arrive", {up4, dn4, sd4, fl4, at4, ft4}, mk(0, 1, 2'b10, 0, 1, 3'b000));
        cycle(2'b00, 2'b00);
        check("half_down_pulse_end", {up4, dn4, sd4, fl4, at4, ft4}, mk(0, 0, 2'b10, 0, 1, 3'b000));

        // Reset mid-move, on the edge that would otherwise fire sensor_up.
        cycle(2'b11, 2'b00);
        for (int c = 1; c <= 7; c++) cycle(2'b01, 2'b00);
        check("pre_reset_state", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 0, 3'b100));
        reset  = 1'b0;
        engine = 2'b01;
        @(posedge clock);
        #1;
        check("reset_mid_move", {up0, dn0, sd0, fl0, at0, ft0}, mk(0, 0, 2'b10, 0, 1, 3'b000));
        check("reset_mid_move4", {up4, dn4, sd4, fl4, at4, ft4}, mk(0, 0, 2'b10, 0, 0, 3'b000));
        reset  = 1'b1;
        engine = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
